// File: rtl/feedback_loop_output_verifier.sv
// Response checker for the FeedbackLoop bench: compares a valid-qualified signed 8-bit
// stream against a parameter-stored expected sequence and reports mismatches.
module feedback_loop_output_verifier #(
    parameter int                 DEPTH    = 8,
    parameter logic [DEPTH*8-1:0] EXPECTED = '0,
    parameter int                 SKIP     = 0
) (
    input  logic              system1000,
    input  logic              system1000_rst,
    input  logic signed [7:0] out_o,
    input  logic              valid,
    output logic              done,
    output logic              pass,
    output logic              err_pulse,
    output logic [7:0]        mismatch_count,
    output logic [7:0]        first_err_idx
);

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        SKIPPING,
        CHECKING,
        FINISHED
    } state_t;

    localparam state_t     RST_STATE = state_t'((SKIP == 0) ? CHECKING : SKIPPING);
    localparam logic [7:0] LAST_IDX  = 8'(DEPTH - 1);
    localparam logic [7:0] SKIP_LAST = 8'((SKIP == 0) ? 0 : SKIP - 1);
    localparam logic [7:0] NO_ERR    = 8'hFF;

    state_t                   state_q, state_d;
    logic [7:0]               skip_cnt_q, skip_cnt_d;
    logic [7:0]               idx_q, idx_d;
    logic                     done_q, done_d;
    logic                     pass_q, pass_d;
    logic                     err_q, err_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [7:0]               first_q, first_d;
    logic                     miss;
    logic signed [DATA_W-1:0] exp_mem [256];

    // Full 256-entry table so the 8-bit index needs no truncation; unused slots are constant zero.
    for (genvar i = 0; i < 256; i++) begin : g_exp
        if (i < DEPTH) begin : g_used
            assign exp_mem[i] = EXPECTED[DATA_W*i +: DATA_W];
        end else begin : g_pad
            assign exp_mem[i] = '0;
        end
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Case inequality in simulation so an undriven (X/Z) sample always counts as a mismatch.
    function automatic logic sample_differs(input logic signed [DATA_W-1:0] a,
                                            input logic signed [DATA_W-1:0] b);
`ifdef SYNTHESIS
        return a != b;
`else
        return a !== b;
`endif
    endfunction

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        idx_d      = idx_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        first_d    = first_q;
        miss       = 1'b0;
        case (state_q)
            SKIPPING: begin
                if (valid) begin
                    skip_cnt_d = skip_cnt_q + 8'd1;
                    if (skip_cnt_q == SKIP_LAST) begin
                        state_d = CHECKING;
                    end
                end
            end
            CHECKING: begin
                if (valid) begin
                    miss  = sample_differs(out_o, exp_mem[idx_q]);
                    idx_d = idx_q + 8'd1;
                    if (miss) begin
                        err_d = 1'b1;
                        cnt_d = sat_inc(cnt_q);
                        if (first_q == NO_ERR) begin
                            first_d = idx_q;
                        end
                    end
                    // pass uses the count including this final compare
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISHED;
                        done_d  = 1'b1;
                        pass_d  = (cnt_d == 8'd0);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state_q    <= RST_STATE;
            skip_cnt_q <= 8'd0;
            idx_q      <= 8'd0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 8'd0;
            first_q    <= NO_ERR;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
        end
    end

    assign done           = done_q;
    assign pass           = pass_q;
    assign err_pulse      = err_q;
    assign mismatch_count = cnt_q;
    assign first_err_idx  = first_q;

endmodule

// File: doc/feedback_loop_output_verifier.md
# feedback_loop_output_verifier

Synthesizable response checker for the FeedbackLoop top entity. It is the consuming end of the testbench stimulus path. It samples the DUT's signed 8-bit `out_o` stream, compares each valid sample against a parameter-stored expected sequence, counts mismatches and records the first failing index. Once the sequence is exhausted it raises `done`, which the testbench wires to its `finished` net to end simulation.

## Interface

Parameters:
- `DEPTH`, default 8: number of expected samples, range 1..255.
- `EXPECTED`, default all zeros (`DEPTH*8` bits): packed signed 8-bit expected values. Sample 0 is in bits [7:0]; sample i is in bits [8i+7:8i].
- `SKIP`, default 0: number of valid samples discarded before comparison starts (covers DUT pipeline latency), range 0..255.

Ports (one clock; reset is asynchronous and active-high):
- `system1000` input, 1 bit: clock; all state changes on the rising edge.
- `system1000_rst` input, 1 bit: asynchronous active-high reset.
- `out_o` input, 8 bits signed: DUT output sample.
- `valid` input, 1 bit: `out_o` is a meaningful sample this cycle.
- `done` output, 1 bit: sequence checked; stays high until reset.
- `pass` output, 1 bit: high only when `done` is high and `mismatch_count` is 0.
- `err_pulse` output, 1 bit: one-cycle pulse on each mismatching compare.
- `mismatch_count` output, 8 bits: number of mismatches; saturates at 255.
- `first_err_idx` output, 8 bits: index of the first mismatch; 8'hFF if there has been none.

## Operation

State machine with three states: SKIPPING, CHECKING, FINISHED.
- **Reset:** state is SKIPPING, or CHECKING if `SKIP`=0. Outputs and counters on reset:
  - skip counter = 0, index = 0
  - `done`=0, `pass`=0, `err_pulse`=0
  - `mismatch_count`=0, `first_err_idx`=8'hFF
- **SKIPPING:**
  - Each `valid` cycle increments the skip counter.
  - On the `SKIP`-th valid sample, move to CHECKING. That sample is not compared.
  - `valid`=0 cycles change nothing.
- **CHECKING:** on a `valid` cycle, compare `out_o` with `EXPECTED[index]` as a full 8-bit signed equality.
  - On mismatch:
    - `err_pulse`=1 on the next cycle.
    - `mismatch_count` increments, saturating at 255.
    - If `first_err_idx`==8'hFF, load it with `index`.
  - `index` increments each valid cycle.
  - When `index`==`DEPTH-1` is compared, move to FINISHED.
- **FINISHED:**
  - `done`=1 and `pass`=(`mismatch_count`==0).
  - Further `valid` samples are ignored; no counters change.
  - Stays here until reset.
- `out_o` with X/Z bits (an undriven DUT) must count as a mismatch in simulation. Use `!==`-style case inequality behind translate_off, with plain inequality for synthesis.
- **Reset mid-operation:** all state returns immediately, asynchronously, to reset values, and the sequence restarts from index 0 with a fresh skip count.
- `valid` held low indefinitely: no progress and no timeout. The timeout belongs to the testbench.

## Timing

- All outputs are registered.
- A compare performed at edge N is visible on `err_pulse`, `mismatch_count` and `first_err_idx` after edge N.
- `done` and `pass` go high after the edge that compares the last sample, i.e. one cycle after that sample's `valid`.
- `err_pulse` lasts exactly one cycle per mismatch. Back-to-back mismatches give a continuous high.
- Reset deassertion is synchronized by the caller. The first sample accepted is the one on the first rising edge where reset is low.
- Latency from a `valid` sample to the outputs reflecting it is 1 cycle.
- Throughput is one sample per cycle.

## Test plan

Common settings for scenarios 1–4 and 6: `DEPTH`=4, `EXPECTED`={8'sd4, 8'sd3, 8'sd2, 8'sd1}, `SKIP`=0.

1. **Clean pass:** drive 1, 2, 3, 4 with `valid`=1 on four consecutive cycles.
   - `done`=1 and `pass`=1 one cycle after the 4th sample.
   - `mismatch_count`=0, `first_err_idx`=8'hFF.
2. **Single error:** drive 1, 2, -3, 4.
   - `err_pulse` high for exactly one cycle after the 3rd sample.
   - `mismatch_count`=1, `first_err_idx`=2, `done`=1, `pass`=0.
3. **Gapped valid and trailing samples:** drive 1, 2, 3, 4 with `valid` low for 2 cycles between each sample, then extra samples after `done`.
   - Same result as scenario 1.
   - `done` lands 1 cycle after the 4th valid sample.
   - Extra samples after `done` leave `mismatch_count` at 0.
4. **Skip latency:** `SKIP`=2; drive 9, 9, 1, 2, 3, 4.
   - `pass`=1; the two leading 9s are never compared.
5. **Saturation and undriven input:** `DEPTH`=255, all expected 0, `out_o` driven X (undriven) throughout.
   - `mismatch_count`=255, `first_err_idx`=0, `pass`=0.
6. **Async reset mid-run:** drive 1, 7 (one error so far), then pulse `system1000_rst` between clock edges.
   - All outputs return to reset values immediately, without waiting for an edge.
   - After reset, drive 1, 2, 3, 4: result is `pass`=1.
